// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle subtractor computing d = a - b - bin, one
// 4-bit nibble per clock, LSB first, with a registered borrow chained between nibbles.
// Latency: accept at edge k, result valid from edge k+NIB. Holds the result in DONE until out_ready.
// Ports: clk/rst (async, active-high); in_valid/in_ready with a, b, bin;
//        out_valid/out_ready with d, bout, zf, nf, vf.
// Optional build macro NSUB_SAT_EN: clamp d to the signed limit on overflow.
module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       sum;
  logic [WIDTH-1:0] d_upd;
  logic [WIDTH-1:0] d_fin;
  logic             vf_c;
  logic             last;

  // Nibble select, 4-bit add and merge of the new nibble into the partial result.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_r[4*i +: 4];
        b_nib = b_r[4*i +: 4];
      end
    end
    // Subtraction as a + ~b + ~borrow; carry out is the inverted borrow.
    sum   = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, ~borrow};
    d_upd = d;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        d_upd[4*i +: 4] = sum[3:0];
      end
    end
  end

  assign last = (cnt == CW'(NIB - 1));
  // Only meaningful on the last nibble, when d_upd holds the complete difference.
  assign vf_c = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_upd[WIDTH-1] != a_r[WIDTH-1]);

`ifdef NSUB_SAT_EN
  // Clamp toward the sign of the minuend: positive -> max, negative -> min.
  always_comb begin
    d_fin = d_upd;
    if (vf_c) begin
      d_fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign d_fin = d_upd;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE first keeps the accept off this cycle.
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, per-nibble result, flags on the final nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      borrow <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      d      <= '0;
      bout   <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      vf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          borrow <= ~sum[4];
          if (last) begin
            cnt  <= '0;
            d    <= d_fin;
            bout <= ~sum[4];
            zf   <= (d_fin == '0);
            nf   <= d_fin[WIDTH-1];
            vf   <= vf_c;
          end else begin
            cnt <= cnt + 1'b1;
            d   <= d_upd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
module tb_nibble_serial_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         zf;
  logic         nf;
  logic         vf;

  int total = 0;
  int fails = 0;

  nibble_serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .zf        (zf),
    .nf        (nf),
    .vf        (vf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] ed, input logic eb,
                           input logic ez, input logic en, input logic ev);
    check({tag, ".d"},    32'(d),    32'(ed));
    check({tag, ".bout"}, 32'(bout), 32'(eb));
    check({tag, ".zf"},   32'(zf),   32'(ez));
    check({tag, ".nf"},   32'(nf),   32'(en));
    check({tag, ".vf"},   32'(vf),   32'(ev));
  endtask

  // Presents operands for one cycle, then counts cycles to out_valid (bounded).
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                    output int lat);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Takes the result and confirms the return to IDLE.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [W-1:0] held_d;
    logic [W-1:0] exp_d3;
    logic         exp_n3;
    logic [W-1:0] exp_d5;
    logic         exp_n5;

`ifdef NSUB_SAT_EN
    exp_d3 = 16'h8000; exp_n3 = 1'b1;
    exp_d5 = 16'h7FFF; exp_n5 = 1'b0;
`else
    exp_d3 = 16'h7FFF; exp_n3 = 1'b0;
    exp_d5 = 16'h8000; exp_n5 = 1'b1;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic, latency 4
    op(16'h1234, 16'h0234, 1'b0, lat);
    check("t1.latency", 32'(lat), 32'd4);
    check_res("t1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("t1");

    // 2: underflow wraps
    op(16'h0000, 16'h0001, 1'b0, lat);
    check("t2.latency", 32'(lat), 32'd4);
    check_res("t2", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    consume("t2");

    // 3: signed overflow, negative minuend
    op(16'h8000, 16'h0001, 1'b0, lat);
    check_res("t3", exp_d3, 1'b0, 1'b0, exp_n3, 1'b1);
    consume("t3");

    // 4: equal operands, with and without borrow in
    op(16'h5555, 16'h5555, 1'b0, lat);
    check_res("t4a", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    consume("t4a");
    op(16'h5555, 16'h5555, 1'b1, lat);
    check_res("t4b", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    consume("t4b");

    // 5: stall in DONE with new operands presented
    op(16'h00FF, 16'h0F00, 1'b0, lat);
    check_res("t5a", 16'hF1FF, 1'b1, 1'b0, 1'b1, 1'b0);
    held_d = d;
    a = 16'h7FFF; b = 16'hFFFF; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t5.hold_d",     32'(d),         32'(held_d));
      check("t5.hold_vld",   32'(out_valid), 32'd1);
      check("t5.hold_rdy",   32'(in_ready),  32'd0);
    end
    check_res("t5hold", 16'hF1FF, 1'b1, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("t5.idle_rdy", 32'(in_ready),  32'd1);
    check("t5.idle_vld", 32'(out_valid), 32'd0);
    check("t5.idle_d",   32'(d),         32'(held_d));
    @(posedge clk);          // accept of the waiting operands
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5.run_rdy", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("t5.latency", 32'(lat), 32'd4);
    check_res("t5b", exp_d5, 1'b1, 1'b0, exp_n5, 1'b1);
    consume("t5b");

    // 6: reset during the second RUN cycle
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);          // accept
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);          // first RUN edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6.out_valid", 32'(out_valid), 32'd0);
    check("t6.in_ready",  32'(in_ready),  32'd1);
    check("t6.d",         32'(d),         32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("t6.no_result", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
